mos_param: RTL and testbench



---
 rtl/mos_param.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mos_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mos_param.sv
// mos_param: runtime-sized N x N matrix multiply (C = X * W), streamed in and
// reduced to the 2N-1 anti-diagonal sums D[d] = sum(C[i][j], i + j == d).
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (IDLE / LOAD_W / LOAD_X)
//   in_size    N-1, sampled on the first accepted beat of a job only
//   in_data    signed operand (N*N W beats then N*N X beats, row-major)
//   out_valid  result beat valid
//   out_ready  consumer accepts the beat
//   out_data   signed anti-diagonal sum D[0] .. D[2N-2], 0 while idle
//   out_last   marks D[2N-2]
//   busy       high whenever the FSM is not in IDLE
//
// Build option
//   MOS_PARAM_SAT_EN  defined: D values are clamped to the signed OUT_W range.
//                     undefined: D values wrap to their low OUT_W bits.

module mos_param #(
    parameter int unsigned MAX_N  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 40,
    parameter int unsigned SIZE_W = $clog2(MAX_N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE_W-1:0]        in_size,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy
);

    // Wide enough that no product or sum of a job can overflow.
    localparam int unsigned ACC_W   = 2 * DATA_W + 2 * $clog2(MAX_N);
    // D index spans 0 .. 2*MAX_N-2; one spare entry keeps the array a power of two.
    localparam int unsigned D_IDX_W = SIZE_W + 1;
    localparam int unsigned D_NUM   = 2 * MAX_N;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadX,
        StCalc,
        StOut
    } state_e;

    state_e state_q, state_d;

    // Operand storage and arithmetic state
    logic signed [DATA_W-1:0] w_q   [MAX_N][MAX_N];
    logic signed [DATA_W-1:0] x_q   [MAX_N][MAX_N];
    logic signed [ACC_W-1:0]  acc_q [MAX_N];
    logic signed [ACC_W-1:0]  d_q   [D_NUM];

    // Control registers
    logic [SIZE_W-1:0]  size_q;
    logic [SIZE_W-1:0]  ld_row_q, ld_col_q;
    logic [SIZE_W-1:0]  calc_row_q, calc_k_q;
    logic               fold_q;
    logic [D_IDX_W-1:0] out_idx_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic               in_ready_q, in_ready_d;
    logic               busy_q;

    // Combinational helpers
    logic                     in_acc;
    logic                     load_last;
    logic [MAX_N-1:0]         lane_en;
    logic [D_IDX_W-1:0]       didx [MAX_N];
    logic signed [ACC_W-1:0]  prod [MAX_N];
    logic signed [DATA_W-1:0] x_cur;
    logic [D_IDX_W-1:0]       load_idx;
    logic [D_IDX_W-1:0]       last_idx;
    logic signed [ACC_W-1:0]  d_sel;
    logic signed [OUT_W-1:0]  d_conv;

    assign in_acc    = in_valid && in_ready_q;
    assign load_last = (ld_row_q == size_q) && (ld_col_q == size_q);
    assign x_cur     = x_q[calc_row_q][calc_k_q];
    assign last_idx  = {size_q, 1'b0};

    // First OUT cycle primes D[0]; afterwards each accepted beat fetches the next entry.
    assign load_idx  = out_valid_q ? (out_idx_q + D_IDX_W'(1)) : out_idx_q;
    assign d_sel     = d_q[load_idx];

    always_comb begin
        for (int j = 0; j < int'(MAX_N); j++) begin
            lane_en[j] = (SIZE_W'(j) <= size_q);
            didx[j]    = D_IDX_W'(calc_row_q) + D_IDX_W'(j);
            // Casts sign-extend both operands, so the product is full precision.
            prod[j]    = ACC_W'(x_cur) * ACC_W'(w_q[calc_k_q][j]);
        end
    end

    // ACC_W -> OUT_W conversion of the entry about to be presented
    generate
        if (OUT_W >= ACC_W) begin : g_out_wide
            assign d_conv = OUT_W'(d_sel);
        end else begin : g_out_narrow
`ifdef MOS_PARAM_SAT_EN
            localparam logic [OUT_W-1:0] MaxOut = {1'b0, {(OUT_W - 1){1'b1}}};
            localparam logic [OUT_W-1:0] MinOut = {1'b1, {(OUT_W - 1){1'b0}}};
            logic in_range;
            // Representable iff all bits from the OUT_W sign bit upward agree.
            assign in_range = (&d_sel[ACC_W-1:OUT_W-1]) | ~(|d_sel[ACC_W-1:OUT_W-1]);
            always_comb begin
                if (in_range) begin
                    d_conv = OUT_W'(d_sel);
                end else if (d_sel[ACC_W-1]) begin
                    d_conv = MinOut;
                end else begin
                    d_conv = MaxOut;
                end
            end
`else
            assign d_conv = OUT_W'(d_sel);
`endif
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_acc) begin
                    // N=1 has no further W beats, so skip straight to X.
                    state_d = (in_size == '0) ? StLoadX : StLoadW;
                end
            end
            StLoadW: begin
                if (in_acc && load_last) state_d = StLoadX;
            end
            StLoadX: begin
                if (in_acc && load_last) state_d = StCalc;
            end
            StCalc: begin
                if (fold_q && (calc_row_q == size_q)) state_d = StOut;
            end
            StOut: begin
                if (out_valid_q && out_ready && out_last_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready_d = (state_d == StIdle) || (state_d == StLoadW) || (state_d == StLoadX);

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            size_q      <= '0;
            ld_row_q    <= '0;
            ld_col_q    <= '0;
            calc_row_q  <= '0;
            calc_k_q    <= '0;
            fold_q      <= 1'b0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= (state_d != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (in_acc) begin
                        size_q   <= in_size;
                        ld_row_q <= '0;
                        ld_col_q <= (in_size == '0) ? '0 : SIZE_W'(1);
                    end
                end
                StLoadW, StLoadX: begin
                    if (in_acc) begin
                        if (load_last) begin
                            ld_row_q <= '0;
                            ld_col_q <= '0;
                        end else if (ld_col_q == size_q) begin
                            ld_col_q <= '0;
                            ld_row_q <= ld_row_q + SIZE_W'(1);
                        end else begin
                            ld_col_q <= ld_col_q + SIZE_W'(1);
                        end
                    end
                    calc_row_q <= '0;
                    calc_k_q   <= '0;
                    fold_q     <= 1'b0;
                end
                StCalc: begin
                    if (fold_q) begin
                        fold_q   <= 1'b0;
                        calc_k_q <= '0;
                        if (calc_row_q == size_q) begin
                            out_idx_q <= '0;
                        end else begin
                            calc_row_q <= calc_row_q + SIZE_W'(1);
                        end
                    end else if (calc_k_q == size_q) begin
                        fold_q <= 1'b1;
                    end else begin
                        calc_k_q <= calc_k_q + SIZE_W'(1);
                    end
                end
                StOut: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= d_conv;
                        out_last_q  <= (load_idx == last_idx);
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_idx_q  <= load_idx;
                            out_data_q <= d_conv;
                            out_last_q <= (load_idx == last_idx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage and arithmetic; stale contents are cleared at the start of each job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_acc && (state_q == StIdle)) begin
                w_q[0][0] <= in_data;
                for (int j = 0; j < int'(MAX_N); j++) begin
                    acc_q[j] <= '0;
                end
                for (int d = 0; d < int'(D_NUM); d++) begin
                    d_q[d] <= '0;
                end
            end
            if (in_acc && (state_q == StLoadW)) begin
                w_q[ld_row_q][ld_col_q] <= in_data;
            end
            if (in_acc && (state_q == StLoadX)) begin
                x_q[ld_row_q][ld_col_q] <= in_data;
            end
            if (state_q == StCalc) begin
                if (!fold_q) begin
                    for (int j = 0; j < int'(MAX_N); j++) begin
                        if (lane_en[j]) acc_q[j] <= acc_q[j] + prod[j];
                    end
                end else begin
                    // Row i done: lane j holds C[i][j], which belongs to D[i+j].
                    for (int j = 0; j < int'(MAX_N); j++) begin
                        if (lane_en[j]) d_q[didx[j]] <= d_q[didx[j]] + acc_q[j];
                        acc_q[j] <= '0;
                    end
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mos_param.sv
module tb_mos_param;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [2:0]         in_size;
    logic signed [15:0] in_data;
    logic               out_ready;

    logic               in_ready, out_valid, out_last, busy;
    logic signed [39:0] out_data;
    logic               in_ready1, out_valid1, out_last1, busy1;
    logic signed [31:0] out_data1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mos_param #(.MAX_N(8), .DATA_W(16), .OUT_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_size   (in_size),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Narrow-output copy driven by the same stream, for the OUT_W < ACC_W conversion.
    mos_param #(.MAX_N(8), .DATA_W(16), .OUT_W(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_size   (in_size),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .out_last  (out_last1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint conv32(input longint v);
        logic signed [31:0] t;
`ifdef MOS_PARAM_SAT_EN
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        t = v[31:0];
        return longint'(t);
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One input beat; returns one step after the accepting edge with in_valid low.
    task automatic put(input int sz, input longint d);
        int guard = 0;
        in_valid = 1'b1;
        in_size  = sz[2:0];
        in_data  = d[15:0];
        while (in_ready !== 1'b1 && guard < 200) begin
            cyc();
            guard++;
        end
        if (in_ready !== 1'b1) check("put_timeout", in_ready, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    // in_size is only meaningful on the first beat; later beats carry a wrong value.
    task automatic load_job(input int n, input longint wv[$], input longint xv[$], input int gap);
        for (int i = 0; i < n * n; i++) begin
            put((i == 0) ? (n - 1) : (7 - (n - 1)), wv[i]);
            repeat (gap) cyc();
        end
        for (int i = 0; i < n * n; i++) begin
            put(7 - (n - 1), xv[i]);
            if (i != n * n - 1) repeat (gap) cyc();
        end
    endtask

    task automatic wait_first(input string tag, input int exp_lat);
        int lat = 0;
        out_ready = 1'b1;
        check({tag, "_idle_data"}, out_data, 0);
        check({tag, "_calc_ready"}, in_ready, 0);
        while (out_valid !== 1'b1 && lat < 200) begin
            cyc();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic drain(input string tag, input longint exp[$], input int stall_at,
                         input int stall_n);
        int guard;
        int n = exp.size();
        out_ready = 1'b1;
        for (int b = 0; b < n; b++) begin
            guard = 0;
            while (out_valid !== 1'b1 && guard < 200) begin
                cyc();
                guard++;
            end
            check($sformatf("%s_valid%0d", tag, b), out_valid, 1);
            check($sformatf("%s_data%0d", tag, b), out_data, exp[b]);
            check($sformatf("%s_last%0d", tag, b), out_last, (b == n - 1));
            check($sformatf("%s_inrdy%0d", tag, b), in_ready, 0);
            check($sformatf("%s_busy%0d", tag, b), busy, 1);
            check($sformatf("%s_d32_%0d", tag, b), out_data1, conv32(exp[b]));
            check($sformatf("%s_v32_%0d", tag, b), out_valid1, 1);
            check($sformatf("%s_l32_%0d", tag, b), out_last1, (b == n - 1));
            if (b == stall_at) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    cyc();
                    check($sformatf("%s_hold_data%0d", tag, b), out_data, exp[b]);
                    check($sformatf("%s_hold_valid%0d", tag, b), out_valid, 1);
                    check($sformatf("%s_hold_inrdy%0d", tag, b), in_ready, 0);
                end
                out_ready = 1'b1;
            end
            cyc();
        end
        cyc();
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_ready"}, in_ready, 1);
        check({tag, "_end_valid"}, out_valid, 0);
        check({tag, "_end_data"}, out_data, 0);
        check({tag, "_end_last"}, out_last, 0);
        check({tag, "_end_busy32"}, busy1, 0);
        check({tag, "_end_ready32"}, in_ready1, 1);
    endtask

    initial begin
        longint w2[$] = '{1, 2, 3, 4};
        longint x2[$] = '{5, 6, 7, 8};
        // C = X*W = [[23,34],[31,46]] -> D = 23, 34+31, 46
        longint e2[$] = '{23, 65, 46};
        longint w1[$] = '{-3};
        longint x1[$] = '{7};
        longint e1[$] = '{-21};
        longint w8[$];
        longint e8[$];
        int cnt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_size   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) cyc();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        cyc();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        // N=2 basic job
        load_job(2, w2, x2, 0);
        wait_first("n2", 7);
        drain("n2", e2, -1, 0);

        // N=1; in_valid held high with junk while the block is not ready
        load_job(1, w1, x1, 0);
        in_valid = 1'b1;
        in_data  = 16'sh7fff;
        wait_first("n1", 3);
        in_valid = 1'b0;
        drain("n1", e1, -1, 0);

        // N=8, every operand -32768: C entries are 2^33 each
        for (int i = 0; i < 64; i++) w8.push_back(-32768);
        for (int d = 0; d < 15; d++) begin
            cnt = (d + 1 < 15 - d) ? (d + 1) : (15 - d);
            e8.push_back(longint'(cnt) * 64'sd8589934592);
        end
        check("n8_model_d0", e8[0], 64'sd8589934592);
        check("n8_model_d7", e8[7], 64'sd68719476736);
        load_job(8, w8, w8, 0);
        wait_first("n8", 73);
        drain("n8", e8, -1, 0);

        // N=2 with input gaps and a 3-cycle output stall on the middle beat
        load_job(2, w2, x2, 2);
        wait_first("gap", 7);
        drain("gap", e2, 1, 3);

        // Reset in the middle of LOAD_W, then a clean job
        put(1, 1);
        put(6, 2);
        put(6, 3);
        check("mid_in_ready", in_ready, 1);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        cyc();
        check("mid_rst_ready_rise", in_ready, 1);
        load_job(2, w2, x2, 0);
        wait_first("after_rst", 7);
        drain("after_rst", e2, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
